// File: rtl/raster_pkg.sv
// Shared definitions for the fragment writer: FSM encoding, buffer selects, address sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package raster_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        TEST     = 3'd3,
        WR_DEPTH = 3'd4,
        WR_COLOR = 3'd5,
        DISCARD  = 3'd6
    } state_t;

    localparam logic SEL_DEPTH = 1'b0;
    localparam logic SEL_COLOR = 1'b1;

    // Smallest width able to index 'pixels' distinct locations.
    function automatic int addr_width(input int unsigned pixels);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(pixels)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/frag_fifo.sv
// Generic synchronous FIFO, first-word fall-through read port.
// Latency: a push is visible on pop_dat the cycle after it is written.
// Backpressure: push ignored while full, pop ignored while empty; fullness is start-of-cycle.
module frag_fifo #(
    parameter int DAT_W = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [DAT_W-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [DAT_W-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DAT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fragment_writer.sv
// Queues fragments, optionally depth-tests them against memory, then writes depth and color.
// Latency: first mem_req 2 cycles after the push; 7 cycles pop-to-IDLE for a tested fragment.
// Backpressure: none upstream (full FIFO drops and flags overflow); memory stalls via mem_ready.
module fragment_writer
    import raster_pkg::*;
#(
    parameter  int COORD_W    = 32,
    parameter  int COLOR_W    = 24,
    parameter  int DEPTH_W    = 32,
    parameter  int SCREEN_W   = 1024,
    parameter  int SCREEN_H   = 1024,
    parameter  int FIFO_DEPTH = 16,
    localparam int ADDR_W     = addr_width(SCREEN_W * SCREEN_H)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [COORD_W-1:0] frag_x,
    input  logic [COORD_W-1:0] frag_y,
    input  logic [COLOR_W-1:0] color_r,
    input  logic [COLOR_W-1:0] color_g,
    input  logic [COLOR_W-1:0] color_b,
    input  logic [DEPTH_W-1:0] depth,
    input  logic               depth_test_enable,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_sel,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DEPTH_W-1:0] mem_wdata,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [DEPTH_W-1:0] mem_rdata,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        pass_count,
    output logic [15:0]        reject_count
);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [7:0]         r;
        logic [7:0]         g;
        logic [7:0]         b;
        logic [DEPTH_W-1:0] depth;
        logic               dte;
    } frag_t;

    state_t             state;
    state_t             state_nxt;
    frag_t              in_frag;
    frag_t              head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               in_bounds;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DEPTH_W-1:0] cur_depth;
    logic [23:0]        cur_color;
    logic [DEPTH_W-1:0] stored_depth;

    // Only the low byte of each channel reaches the color buffer.
    logic unused_color_hi;
    assign unused_color_hi = ^{color_r[COLOR_W-1:8], color_g[COLOR_W-1:8], color_b[COLOR_W-1:8]};

    assign in_frag = '{x: frag_x, y: frag_y, r: color_r[7:0], g: color_g[7:0],
                       b: color_b[7:0], depth: depth, dte: depth_test_enable};

    frag_fifo #(
        .DAT_W($bits(frag_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (valid_in),
        .push_dat (in_frag),
        .pop_rdy  (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pop       = (state == IDLE) && !fifo_empty;
    assign in_bounds = (head.x < COORD_W'(SCREEN_W)) && (head.y < COORD_W'(SCREEN_H));
    assign busy      = !fifo_empty || (state != IDLE);
    assign mem_addr  = cur_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (!in_bounds)    state_nxt = DISCARD;
                    else if (head.dte) state_nxt = RD_REQ;
                    else               state_nxt = WR_DEPTH;
                end
            end
            RD_REQ:   if (mem_ready)  state_nxt = RD_WAIT;
            RD_WAIT:  if (mem_rvalid) state_nxt = TEST;
            TEST:     state_nxt = (cur_depth < stored_depth) ? WR_DEPTH : DISCARD;
            WR_DEPTH: if (mem_ready)  state_nxt = WR_COLOR;
            WR_COLOR: if (mem_ready)  state_nxt = IDLE;
            DISCARD:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Request fields derive from state and latched registers only, so they hold until accepted.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = SEL_DEPTH;
        mem_wdata = '0;
        case (state)
            RD_REQ: begin
                mem_req = 1'b1;
            end
            WR_DEPTH: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = cur_depth;
            end
            WR_COLOR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_sel   = SEL_COLOR;
                mem_wdata = DEPTH_W'(cur_color);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr     <= '0;
            cur_depth    <= '0;
            cur_color    <= '0;
            stored_depth <= '0;
            overflow     <= 1'b0;
            pass_count   <= '0;
            reject_count <= '0;
        end else begin
            if (pop) begin
                cur_addr  <= ADDR_W'(head.y * COORD_W'(SCREEN_W) + head.x);
                cur_depth <= head.depth;
                cur_color <= {head.r, head.g, head.b};
            end
            if ((state == RD_WAIT) && mem_rvalid) begin
                stored_depth <= mem_rdata;
            end
            if (valid_in && fifo_full) begin
                overflow <= 1'b1;
            end
            if ((state == WR_COLOR) && mem_ready && (pass_count != 16'hFFFF)) begin
                pass_count <= pass_count + 16'd1;
            end
            if ((state == DISCARD) && (reject_count != 16'hFFFF)) begin
                reject_count <= reject_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fragment_writer.sv
// Randomized bench for fragment_writer with a transaction-level reference model and memory responder.
// Latency: n/a. Backpressure: responder drives mem_ready/mem_rvalid per test knobs.
module tb_fragment_writer;

    localparam int COORD_W    = 32;
    localparam int COLOR_W    = 24;
    localparam int DEPTH_W    = 32;
    localparam int SCREEN_W   = 1024;
    localparam int SCREEN_H   = 1024;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = 20;
    localparam logic [31:0] DEF_DEPTH = 32'h80;  // depth of never-written pixels

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0;
    logic [COORD_W-1:0] frag_x = '0;
    logic [COORD_W-1:0] frag_y = '0;
    logic [COLOR_W-1:0] color_r = '0;
    logic [COLOR_W-1:0] color_g = '0;
    logic [COLOR_W-1:0] color_b = '0;
    logic [DEPTH_W-1:0] depth = '0;
    logic               depth_test_enable = 1'b0;
    logic               mem_req;
    logic               mem_we;
    logic               mem_sel;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DEPTH_W-1:0] mem_wdata;
    logic               mem_ready = 1'b0;
    logic               mem_rvalid = 1'b0;
    logic [DEPTH_W-1:0] mem_rdata = '0;
    logic               busy;
    logic               overflow;
    logic [15:0]        pass_count;
    logic [15:0]        reject_count;

    fragment_writer #(
        .COORD_W(COORD_W), .COLOR_W(COLOR_W), .DEPTH_W(DEPTH_W),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .frag_x(frag_x), .frag_y(frag_y),
        .color_r(color_r), .color_g(color_g), .color_b(color_b), .depth(depth),
        .depth_test_enable(depth_test_enable), .mem_req(mem_req), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .overflow(overflow),
        .pass_count(pass_count), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        we;
        bit        sel;
        bit [19:0] addr;
        bit [31:0] wdata;
    } txn_t;

    txn_t      expq[$];
    bit [31:0] ref_depth [bit [19:0]];
    bit [31:0] mem_depth [bit [19:0]];
    int        exp_pass = 0;
    int        exp_rej  = 0;

    task automatic preload(input bit [19:0] a, input bit [31:0] v);
        ref_depth[a] = v;
        mem_depth[a] = v;
    endtask

    // Expected memory traffic and counter effect of one accepted fragment, in arrival order.
    task automatic model_frag(input int unsigned x, input int unsigned y, input bit [23:0] r,
                              input bit [23:0] g, input bit [23:0] b, input bit [31:0] d,
                              input bit dte);
        txn_t      t;
        bit [19:0] a;
        bit [31:0] stored;
        if (x >= SCREEN_W || y >= SCREEN_H) begin
            exp_rej++;
            return;
        end
        a = 20'(y * SCREEN_W + x);
        stored = ref_depth.exists(a) ? ref_depth[a] : DEF_DEPTH;
        if (dte) begin
            t.we = 0; t.sel = 0; t.addr = a; t.wdata = 0;
            expq.push_back(t);
        end
        if (dte && !(d < stored)) begin
            exp_rej++;
        end else begin
            t.we = 1; t.sel = 0; t.addr = a; t.wdata = d;
            expq.push_back(t);
            t.sel = 1;
            t.wdata = ((32'(r) & 32'hFF) << 16) | ((32'(g) & 32'hFF) << 8) | (32'(b) & 32'hFF);
            expq.push_back(t);
            ref_depth[a] = d;
            exp_pass++;
        end
    endtask

    // ---------------- memory responder / monitor ----------------
    int        ready_mode  = 0;  // 0 always ready, 1 random, 2 never
    bit        rvalid_auto = 1;
    bit        rnd_delay   = 0;
    bit        spur_en     = 0;
    bit        hold_chk    = 0;
    bit        force_rvalid = 0;
    int        rd_due      = 0;
    bit [19:0] rd_addr     = '0;
    int        stall_ctr   = 0;
    int        n_hold      = 0;

    always begin
        txn_t t;
        bit   r;
        @(posedge clk);
        #1;
        if (rst) begin
            rd_due    = 0;
            stall_ctr = 0;
        end
        case (ready_mode)
            0:       r = 1'b1;
            1:       r = ($urandom % 3) != 0;
            default: r = 1'b0;
        endcase
        if (hold_chk && mem_req && mem_we && (mem_sel == 1'b0) && stall_ctr < 5) begin
            r = 1'b0;
            stall_ctr++;
        end
        mem_ready = r;
        if (rd_due > 0) begin
            rd_due--;
            if (rd_due == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_depth.exists(rd_addr) ? mem_depth[rd_addr] : DEF_DEPTH;
            end else begin
                mem_rvalid = 1'b0;
            end
        end else begin
            mem_rvalid = force_rvalid || (spur_en && ($urandom % 6) == 0);
            mem_rdata  = $urandom;
        end

        @(negedge clk);
        if (!rst && mem_req && !mem_ready && hold_chk && mem_we && !mem_sel && expq.size() > 0) begin
            n_hold++;
            check("hold_addr", mem_addr, expq[0].addr);
            check("hold_wdata", mem_wdata, expq[0].wdata);
        end
        if (!rst && mem_req && mem_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_req", 1, 0);
            end else begin
                t = expq.pop_front();
                check("txn_we", mem_we, t.we);
                check("txn_sel", mem_sel, t.sel);
                check("txn_addr", mem_addr, t.addr);
                if (t.we) check("txn_wdata", mem_wdata, t.wdata);
                if (mem_we && !mem_sel) begin
                    mem_depth[mem_addr] = mem_wdata;
                    stall_ctr = 0;
                end
                if (!mem_we && rvalid_auto) begin
                    rd_due  = rnd_delay ? int'($urandom_range(1, 3)) : 1;
                    rd_addr = mem_addr;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int unsigned x, input int unsigned y, input bit [23:0] r,
                        input bit [23:0] g, input bit [23:0] b, input bit [31:0] d,
                        input bit dte, input bit model);
        frag_x = x; frag_y = y;
        color_r = r; color_g = g; color_b = b;
        depth = d; depth_test_enable = dte;
        valid_in = 1'b1;
        if (model) model_frag(x, y, r, g, b, d, dte);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic send_rand(input bit model);
        int unsigned x, y;
        x = (($urandom % 10) == 0) ? $urandom_range(1020, 1030) : $urandom_range(0, 7);
        y = (($urandom % 10) == 0) ? $urandom_range(1020, 1030) : $urandom_range(0, 7);
        send(x, y, 24'($urandom), 24'($urandom), 24'($urandom), $urandom_range(0, 255),
             bit'($urandom % 2), model);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({"idle_", tag}, busy, 0);
        check({"drain_", tag}, expq.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({"pass_", tag}, pass_count, exp_pass);
        check({"rej_", tag}, reject_count, exp_rej);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int   lat, occ;
        int   c0;
        bit   seen;
        txn_t t;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {mem_req, mem_we, mem_sel, mem_addr, mem_wdata}, 0);
        check("rst_stat", {busy, overflow, pass_count, reject_count}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Passing depth test at (10,20): read 20490, write depth, write color.
        preload(20'd20490, 32'h200);
        c0 = int'(cyc);
        send(10, 20, 24'h123456, 24'hABCDEF, 24'h00FF80, 32'h100, 1, 1);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) begin lat = int'(cyc) - c0; break; end
        end
        check("lat_push_to_req", lat, 2);
        occ = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin occ = int'(cyc) - c0; break; end
        end
        // IDLE is regained in cycle c0+7; the pop happened in c0+1, so c0+1..c0+7 spans 7 cycles.
        check("pop_to_idle", occ, 7);
        check("drain_t025", expq.size(), 0);
        @(posedge clk);
        #1;
        check_counts("t025");

        // Same fragment again: stored depth is now equal, so the test fails.
        send(10, 20, 24'h123456, 24'hABCDEF, 24'h00FF80, 32'h100, 1, 1);
        wait_idle("t026", 50);
        check_counts("t026");

        // Out of bounds: no memory traffic at all.
        send(1024, 5, 24'h1, 24'h2, 24'h3, 32'h10, 1, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1;
        end
        check("oob_no_req", seen, 0);
        @(posedge clk);
        #1;
        check_counts("t027");

        // Depth write stalled 5 cycles: address and data must hold.
        hold_chk = 1;
        n_hold = 0;
        send(3, 4, 24'h0A0B0C, 24'h0D0E0F, 24'h101112, 32'h33, 0, 1);
        wait_idle("t029", 50);
        hold_chk = 0;
        check("hold_cycles", n_hold, 5);
        check_counts("t029");

        // Overflow: one fragment parked in the FSM, then 17 back-to-back; the last is dropped.
        ready_mode = 2;
        send_rand(1);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_rand(1);
        check("ovf_pre", overflow, 0);
        send_rand(0);
        check("ovf_set", overflow, 1);
        check("ovf_busy", busy, 1);
        ready_mode = 1;
        rnd_delay  = 1;
        wait_idle("t028", 3000);
        check("ovf_sticky", overflow, 1);
        check_counts("t028");

        // Random bursts, spurious rvalid outside reads, random stalls.
        spur_en = 1;
        for (int k = 0; k < 30; k++) begin
            int n;
            n = int'($urandom_range(1, 8));
            for (int j = 0; j < n; j++) begin
                send_rand(1);
                if (($urandom % 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            wait_idle("rand", 2000);
            check_counts("rand");
        end
        spur_en = 0;

        // Reset while waiting for read data with 3 fragments still queued.
        ready_mode  = 0;
        rnd_delay   = 0;
        rvalid_auto = 0;
        t.we = 0; t.sel = 0; t.addr = 20'(2 * SCREEN_W + 1); t.wdata = 0;
        expq.push_back(t);
        send(1, 2, 24'h1, 24'h2, 24'h3, 32'h1, 1, 0);
        for (int i = 0; i < 3; i++) send(5, 5, 24'h4, 24'h5, 24'h6, 32'h2, 1, 0);
        check("rwait_read_done", expq.size(), 0);
        check("rwait_busy", busy, 1);
        check("rwait_noreq", mem_req, 0);
        rst = 1'b1;
        #1;
        check("arst_outs", {mem_req, mem_we, mem_sel, mem_addr, mem_wdata}, 0);
        check("arst_stat", {busy, overflow, pass_count, reject_count}, 0);
        expq.delete();
        exp_pass = 0;
        exp_rej  = 0;
        @(posedge clk);
        #1;
        force_rvalid = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", {mem_req, busy, pass_count, reject_count}, 0);
        end
        @(posedge clk);
        #1;
        force_rvalid = 0;
        rvalid_auto  = 1;
        send(10, 20, 24'hFF, 24'hEE, 24'hDD, 32'h5, 0, 1);
        wait_idle("post_rst", 50);
        check_counts("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
